// File: rtl/dbi_pkg.sv
// Shared opcodes, state and strobe-phase encodings for the DBI Type-B frame scheduler.
package dbi_pkg;

  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] RASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;

  localparam int unsigned SEQ_LAST = 2;
  localparam int unsigned PAR_LAST = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TE,
    ST_CMD,
    ST_PARAM,
    ST_PXL,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_0,
    PH_1
  } phase_e;

  function automatic logic [7:0] opcode(input logic [1:0] idx);
    case (idx)
      2'd0:    return CASET;
      2'd1:    return RASET;
      default: return RAMWR;
    endcase
  endfunction

endpackage

// File: rtl/dbi_wr_strobe.sv
// Two-phase DBI write slot: phase 0 drives WRX low, phase 1 releases it with D/DCX held.
module dbi_wr_strobe
  import dbi_pkg::*;
#(
  parameter int unsigned DAT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_req,
  input  logic             byte_dcx,
  input  logic [DAT_W-1:0] byte_dat,
  output logic             wrx,
  output logic             dcx,
  output logic [DAT_W-1:0] d,
  output logic             slot_done_c,
  output logic             slot_free_c
);

  phase_e phase, phase_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PH_IDLE;
    else        phase <= phase_n;
  end

  always_comb begin
    phase_n = phase;
    if (byte_req) begin
      phase_n = PH_0;
    end else begin
      case (phase)
        PH_0:    phase_n = PH_1;
        PH_1:    phase_n = PH_IDLE;
        default: phase_n = PH_IDLE;
      endcase
    end
  end

  // D/DCX only change when a new slot is requested, so they are held through phase 1 and stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrx <= 1'b1;
      dcx <= 1'b1;
      d   <= '0;
    end else begin
      wrx <= (phase_n != PH_0);
      if (byte_req) begin
        dcx <= byte_dcx;
        d   <= byte_dat;
      end
    end
  end

  assign slot_done_c = (phase == PH_1);
  assign slot_free_c = (phase != PH_0);

endmodule

// File: rtl/dbi_frame_sched.sv
// Frame sequencer: CASET/RASET/RAMWR then pixel bytes onto the DBI Type-B bus.
// Optional DBI_TE_SYNC_EN adds dbi_te_i and waits for a tearing-effect rising edge before each frame.
module dbi_frame_sched
  import dbi_pkg::*;
#(
  parameter int unsigned IMG_W      = 320,
  parameter int unsigned IMG_H      = 240,
  parameter int unsigned DBI_DAT_W  = 8,
  parameter int unsigned BYTE_CNT_W = $clog2(2 * IMG_W * IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef DBI_TE_SYNC_EN
  input  logic                 dbi_te_i,
`endif
  input  logic                 frame_start_i,
  input  logic [DBI_DAT_W-1:0] rgb_pxl_dat_i,
  input  logic                 rgb_pxl_vld_i,
  output logic                 rgb_pxl_rdy_o,
  output logic                 dbi_csx_o,
  output logic                 dbi_dcx_o,
  output logic                 dbi_wrx_o,
  output logic [DBI_DAT_W-1:0] dbi_d_o,
  output logic                 frame_busy_o,
  output logic                 frame_done_o
);

  localparam int unsigned N_BYTES = 2 * IMG_W * IMG_H;
  localparam logic [15:0] COL_END = 16'(IMG_W - 1);
  localparam logic [15:0] ROW_END = 16'(IMG_H - 1);
  localparam logic [BYTE_CNT_W-1:0] CNT_LAST = BYTE_CNT_W'(N_BYTES - 1);

  if (DBI_DAT_W != 8) begin : g_bad_dat_w
    $error("dbi_frame_sched: only an 8-bit DBI bus is supported");
  end
  if (IMG_W > 65536 || IMG_H > 65536) begin : g_bad_dim
    $error("dbi_frame_sched: IMG_W and IMG_H must not exceed 65536");
  end

  state_e                state, state_n;
  logic [1:0]            seq_idx, seq_idx_n;
  logic [1:0]            par_idx, par_idx_n;
  logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_n;
  logic                  last_q, last_n;

  logic                  byte_req_c;
  logic                  byte_dcx_c;
  logic [DBI_DAT_W-1:0]  byte_dat_c;
  logic                  slot_done_c;
  logic                  slot_free_c;

  function automatic logic [7:0] param_byte(input logic [1:0] seq, input logic [1:0] par);
    logic [15:0] end_addr;
    end_addr = (seq == 2'd0) ? COL_END : ROW_END;
    case (par)
      2'd2:    return end_addr[15:8];
      2'd3:    return end_addr[7:0];
      default: return 8'h00;
    endcase
  endfunction

`ifdef DBI_TE_SYNC_EN
  logic [2:0] te_sync;
  logic       te_rise_c;

  // two flops for metastability, a third to find the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) te_sync <= '0;
    else        te_sync <= {te_sync[1:0], dbi_te_i};
  end
  assign te_rise_c = te_sync[1] & ~te_sync[2];
`endif

  assign rgb_pxl_rdy_o = (state == ST_PXL) & slot_free_c & ~last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      seq_idx  <= '0;
      par_idx  <= '0;
      byte_cnt <= '0;
      last_q   <= 1'b0;
    end else begin
      state    <= state_n;
      seq_idx  <= seq_idx_n;
      par_idx  <= par_idx_n;
      byte_cnt <= byte_cnt_n;
      last_q   <= last_n;
    end
  end

  always_comb begin
    state_n    = state;
    seq_idx_n  = seq_idx;
    par_idx_n  = par_idx;
    byte_cnt_n = byte_cnt;
    last_n     = last_q;
    byte_req_c = 1'b0;
    byte_dcx_c = 1'b1;
    byte_dat_c = '0;
    case (state)
      ST_IDLE: begin
        if (frame_start_i) begin
          seq_idx_n = '0;
`ifdef DBI_TE_SYNC_EN
          state_n   = ST_WAIT_TE;
`else
          state_n    = ST_CMD;
          byte_req_c = 1'b1;
          byte_dcx_c = 1'b0;
          byte_dat_c = DBI_DAT_W'(CASET);
`endif
        end
      end
      ST_WAIT_TE: begin
`ifdef DBI_TE_SYNC_EN
        if (te_rise_c) begin
          state_n    = ST_CMD;
          byte_req_c = 1'b1;
          byte_dcx_c = 1'b0;
          byte_dat_c = DBI_DAT_W'(CASET);
        end
`else
        state_n = ST_IDLE;
`endif
      end
      ST_CMD: begin
        // leave during the RAMWR strobe so the first pixel is taken on its release cycle
        if (seq_idx == 2'(SEQ_LAST)) begin
          if (!slot_free_c) state_n = ST_PXL;
        end else if (slot_done_c) begin
          state_n    = ST_PARAM;
          par_idx_n  = '0;
          byte_req_c = 1'b1;
          byte_dat_c = DBI_DAT_W'(param_byte(seq_idx, 2'd0));
        end
      end
      ST_PARAM: begin
        if (slot_done_c) begin
          byte_req_c = 1'b1;
          if (par_idx == 2'(PAR_LAST)) begin
            state_n    = ST_CMD;
            seq_idx_n  = seq_idx + 2'd1;
            byte_dcx_c = 1'b0;
            byte_dat_c = DBI_DAT_W'(opcode(seq_idx + 2'd1));
          end else begin
            par_idx_n  = par_idx + 2'd1;
            byte_dat_c = DBI_DAT_W'(param_byte(seq_idx, par_idx + 2'd1));
          end
        end
      end
      ST_PXL: begin
        if (last_q) begin
          if (slot_done_c) state_n = ST_DONE;
        end else if (rgb_pxl_vld_i && rgb_pxl_rdy_o) begin
          byte_req_c = 1'b1;
          byte_dat_c = rgb_pxl_dat_i;
          if (byte_cnt == CNT_LAST) last_n = 1'b1;
          else                      byte_cnt_n = byte_cnt + BYTE_CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_n    = ST_IDLE;
        byte_cnt_n = '0;
        last_n     = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // frame-level outputs follow the state being entered so they align with the bus slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbi_csx_o    <= 1'b1;
      frame_busy_o <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      dbi_csx_o    <= !(state_n inside {ST_CMD, ST_PARAM, ST_PXL});
      frame_busy_o <= !(state_n inside {ST_IDLE, ST_DONE});
      frame_done_o <= (state_n == ST_DONE);
    end
  end

  dbi_wr_strobe #(
    .DAT_W(DBI_DAT_W)
  ) u_strobe (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_req    (byte_req_c),
    .byte_dcx    (byte_dcx_c),
    .byte_dat    (byte_dat_c),
    .wrx         (dbi_wrx_o),
    .dcx         (dbi_dcx_o),
    .d           (dbi_d_o),
    .slot_done_c (slot_done_c),
    .slot_free_c (slot_free_c)
  );

endmodule

// File: tb/tb_dbi_frame_sched.sv
// Directed bench for dbi_frame_sched with a 4x2 image (11 header bytes + 16 pixel bytes).
module tb_dbi_frame_sched;

  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 2;
  localparam int N_BUS = 27;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] pxl_dat;
  logic       pxl_vld = 1'b1;
  logic       pxl_rdy;
  logic       csx, dcx, wrx;
  logic [7:0] d;
  logic       busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] bus_q[$];
  int         src_idx = 0;
  logic       src_clr = 1'b0;
  logic       pat_a5 = 1'b0;

  int r_csx_low, r_first_k, r_done_k, r_done_cnt, r_rdy_bad, r_gap_bad, r_stall_chk, r_stall_bad;
  logic r_first_ok, r_done_busy;

`ifdef DBI_TE_SYNC_EN
  logic       te;
  logic       te_auto = 1'b1;
  logic       te_man = 1'b0;
  logic [3:0] te_cnt = '0;
  always @(posedge clk) te_cnt <= te_cnt + 4'd1;
  assign te = te_auto ? te_cnt[2] : te_man;
`endif

  always #5 clk = ~clk;

  // upstream splitter stand-in: advances one byte per accepted handshake
  always @(posedge clk) begin
    if (src_clr) src_idx <= 0;
    else if (pxl_vld && pxl_rdy) src_idx <= src_idx + 1;
  end
  assign pxl_dat = pat_a5 ? (src_idx[0] ? 8'h34 : 8'hA5) : 8'(8'h10 + src_idx);

  // one bus byte per WRX-low cycle
  always @(negedge clk) if (rst_n && !wrx) bus_q.push_back({dcx, d});

  dbi_frame_sched #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef DBI_TE_SYNC_EN
    .dbi_te_i      (te),
`endif
    .frame_start_i (frame_start),
    .rgb_pxl_dat_i (pxl_dat),
    .rgb_pxl_vld_i (pxl_vld),
    .rgb_pxl_rdy_o (pxl_rdy),
    .dbi_csx_o     (csx),
    .dbi_dcx_o     (dcx),
    .dbi_wrx_o     (wrx),
    .dbi_d_o       (d),
    .frame_busy_o  (busy),
    .frame_done_o  (done)
  );

  function automatic logic [8:0] exp_byte(input int i, input logic a5);
    int j;
    j = i - 11;
    case (i)
      0:       return 9'h02A;
      1, 2, 3: return 9'h100;
      4:       return 9'h103;
      5:       return 9'h02B;
      6, 7, 8: return 9'h100;
      9:       return 9'h101;
      10:      return 9'h02C;
      default: return a5 ? (j[0] ? 9'h134 : 9'h1A5) : {1'b1, 8'(8'h10 + j)};
    endcase
  endfunction

  // drives one frame request and gathers bus observations; stall_at<0 disables the vld gap
  task automatic run_frame(input int stall_at, input int restart_at, input logic pulse_on_done);
    int hs, stall_left, last_rise;
    logic prev_wrx, prev_hs, stall_first;
    logic [7:0] held;
    r_csx_low = 0; r_first_k = 0; r_done_k = 0; r_done_cnt = 0;
    r_rdy_bad = 0; r_gap_bad = 0; r_stall_chk = 0; r_stall_bad = 0;
    r_first_ok = 1'b0; r_done_busy = 1'b1;
    hs = 0; stall_left = 0; last_rise = 0; prev_hs = 1'b0; stall_first = 1'b0; held = '0;
    src_clr = 1'b1;
    @(posedge clk); #1;
    src_clr = 1'b0;
    bus_q.delete();
    frame_start = 1'b1;
    pxl_vld = 1'b1;
    prev_wrx = wrx;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      pxl_vld = 1'b1;
      if (prev_hs && wrx !== 1'b0) r_gap_bad++;
      if (csx === 1'b0) begin
        r_csx_low++;
        if (r_first_k == 0) begin
          r_first_k  = k;
          r_first_ok = (dcx === 1'b0 && d === 8'h2A && wrx === 1'b0 && busy === 1'b1);
        end
      end
      if (prev_wrx === 1'b0 && wrx === 1'b1) begin
        if (stall_at < 0 && last_rise != 0 && k - last_rise != 2) r_gap_bad++;
        last_rise = k;
      end
      if (pxl_rdy === 1'b1 && (wrx !== 1'b1 || csx !== 1'b0 || busy !== 1'b1)) r_rdy_bad++;
      if (done === 1'b1) begin
        r_done_cnt++;
        r_done_k = k;
        r_done_busy = busy;
        if (pulse_on_done) frame_start = 1'b1;
      end
      if (k == restart_at) frame_start = 1'b1;
      if (stall_left > 0) begin
        pxl_vld = 1'b0;
        stall_left--;
        if (stall_first) begin
          held = d;
          stall_first = 1'b0;
        end else begin
          r_stall_chk++;
          if (wrx !== 1'b1 || d !== held || csx !== 1'b0) r_stall_bad++;
        end
      end
      prev_hs = pxl_vld && pxl_rdy;
      if (prev_hs) begin
        hs++;
        if (hs == stall_at) begin
          stall_left = 5;
          stall_first = 1'b1;
        end
      end
      prev_wrx = wrx;
      if (r_done_cnt > 0 && k >= r_done_k + 12) break;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (csx !== 1'b1)  begin n_bad++; $display("FAIL reset.csx got %b want 1", csx); end
    n_cmp++; if (dcx !== 1'b1)  begin n_bad++; $display("FAIL reset.dcx got %b want 1", dcx); end
    n_cmp++; if (wrx !== 1'b1)  begin n_bad++; $display("FAIL reset.wrx got %b want 1", wrx); end
    n_cmp++; if (d !== 8'h00)   begin n_bad++; $display("FAIL reset.d got %h want 00", d); end
    n_cmp++; if (pxl_rdy !== 1'b0) begin n_bad++; $display("FAIL reset.rdy got %b want 0", pxl_rdy); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset.busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset.done got %b want 0", done); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_frame();
    pat_a5 = 1'b0;
    run_frame(-1, 0, 1'b0);
    n_cmp++; if (r_first_ok !== 1'b1) begin n_bad++; $display("FAIL frame.first_slot got %b want 1", r_first_ok); end
`ifndef DBI_TE_SYNC_EN
    n_cmp++; if (r_first_k != 1) begin n_bad++; $display("FAIL frame.first_cycle got %0d want 1", r_first_k); end
`endif
    n_cmp++; if (r_csx_low != 54) begin n_bad++; $display("FAIL frame.csx_low got %0d want 54", r_csx_low); end
    n_cmp++; if (r_done_cnt != 1) begin n_bad++; $display("FAIL frame.done_cnt got %0d want 1", r_done_cnt); end
    n_cmp++; if (r_done_k != r_first_k + 54) begin n_bad++; $display("FAIL frame.done_cycle got %0d want %0d", r_done_k, r_first_k + 54); end
    n_cmp++; if (r_done_busy !== 1'b0) begin n_bad++; $display("FAIL frame.busy_at_done got %b want 0", r_done_busy); end
    n_cmp++; if (r_rdy_bad != 0) begin n_bad++; $display("FAIL frame.rdy_phase got %0d want 0", r_rdy_bad); end
    n_cmp++; if (r_gap_bad != 0) begin n_bad++; $display("FAIL frame.wrx_spacing got %0d want 0", r_gap_bad); end
    n_cmp++; if (bus_q.size() != N_BUS) begin n_bad++; $display("FAIL frame.bytes got %0d want %0d", bus_q.size(), N_BUS); end
    for (int i = 0; i < N_BUS && i < bus_q.size(); i++) begin
      n_cmp++;
      if (bus_q[i] !== exp_byte(i, 1'b0)) begin
        n_bad++; $display("FAIL frame.byte[%0d] got %h want %h", i, bus_q[i], exp_byte(i, 1'b0));
      end
    end
  endtask

  task automatic test_a5_stream();
    pat_a5 = 1'b1;
    run_frame(-1, 0, 1'b0);
    n_cmp++; if (r_gap_bad != 0) begin n_bad++; $display("FAIL a5.wrx_spacing got %0d want 0", r_gap_bad); end
    n_cmp++; if (r_rdy_bad != 0) begin n_bad++; $display("FAIL a5.rdy_phase got %0d want 0", r_rdy_bad); end
    n_cmp++; if (bus_q.size() != N_BUS) begin n_bad++; $display("FAIL a5.bytes got %0d want %0d", bus_q.size(), N_BUS); end
    for (int i = 11; i < N_BUS && i < bus_q.size(); i++) begin
      n_cmp++;
      if (bus_q[i] !== exp_byte(i, 1'b1)) begin
        n_bad++; $display("FAIL a5.byte[%0d] got %h want %h", i, bus_q[i], exp_byte(i, 1'b1));
      end
    end
    pat_a5 = 1'b0;
  endtask

  task automatic test_stall();
    pat_a5 = 1'b0;
    run_frame(5, 0, 1'b0);
    n_cmp++; if (r_stall_chk != 4) begin n_bad++; $display("FAIL stall.held_cycles got %0d want 4", r_stall_chk); end
    n_cmp++; if (r_stall_bad != 0) begin n_bad++; $display("FAIL stall.hold got %0d want 0", r_stall_bad); end
    n_cmp++; if (r_csx_low != 58) begin n_bad++; $display("FAIL stall.csx_low got %0d want 58", r_csx_low); end
    n_cmp++; if (r_done_cnt != 1) begin n_bad++; $display("FAIL stall.done_cnt got %0d want 1", r_done_cnt); end
    n_cmp++; if (r_rdy_bad != 0) begin n_bad++; $display("FAIL stall.rdy_phase got %0d want 0", r_rdy_bad); end
    n_cmp++; if (bus_q.size() != N_BUS) begin n_bad++; $display("FAIL stall.bytes got %0d want %0d", bus_q.size(), N_BUS); end
    for (int i = 0; i < N_BUS && i < bus_q.size(); i++) begin
      n_cmp++;
      if (bus_q[i] !== exp_byte(i, 1'b0)) begin
        n_bad++; $display("FAIL stall.byte[%0d] got %h want %h", i, bus_q[i], exp_byte(i, 1'b0));
      end
    end
  endtask

  task automatic test_ignore_start();
    run_frame(-1, 6, 1'b1);
    n_cmp++; if (r_csx_low != 54) begin n_bad++; $display("FAIL ignore.csx_low got %0d want 54", r_csx_low); end
    n_cmp++; if (r_done_cnt != 1) begin n_bad++; $display("FAIL ignore.done_cnt got %0d want 1", r_done_cnt); end
    n_cmp++; if (bus_q.size() != N_BUS) begin n_bad++; $display("FAIL ignore.bytes got %0d want %0d", bus_q.size(), N_BUS); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || csx !== 1'b1) begin n_bad++; $display("FAIL ignore.idle got busy=%b csx=%b want 0/1", busy, csx); end
    run_frame(-1, 0, 1'b0);
    n_cmp++; if (r_done_cnt != 1) begin n_bad++; $display("FAIL ignore.next_done got %0d want 1", r_done_cnt); end
    n_cmp++; if (r_csx_low != 54) begin n_bad++; $display("FAIL ignore.next_csx_low got %0d want 54", r_csx_low); end
    n_cmp++; if (bus_q.size() != N_BUS) begin n_bad++; $display("FAIL ignore.next_bytes got %0d want %0d", bus_q.size(), N_BUS); end
  endtask

  task automatic test_reset_mid_frame();
    int hs;
    logic found;
    hs = 0;
    found = 1'b0;
    pat_a5 = 1'b0;
    src_clr = 1'b1;
    @(posedge clk); #1;
    src_clr = 1'b0;
    frame_start = 1'b1;
    pxl_vld = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      if (hs == 8 && wrx === 1'b0) begin
        found = 1'b1;
        break;
      end
      if (pxl_vld && pxl_rdy) hs++;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rstmid.reach_byte7 got %b want 1", found); end
    n_cmp++; if (d !== 8'h17) begin n_bad++; $display("FAIL rstmid.byte7 got %h want 17", d); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (csx !== 1'b1) begin n_bad++; $display("FAIL rstmid.csx got %b want 1", csx); end
    n_cmp++; if (wrx !== 1'b1) begin n_bad++; $display("FAIL rstmid.wrx got %b want 1", wrx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid.busy got %b want 0", busy); end
    n_cmp++; if (pxl_rdy !== 1'b0) begin n_bad++; $display("FAIL rstmid.rdy got %b want 0", pxl_rdy); end
    n_cmp++; if (d !== 8'h00 || dcx !== 1'b1) begin n_bad++; $display("FAIL rstmid.bus got d=%h dcx=%b want 00/1", d, dcx); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_frame(-1, 0, 1'b0);
    n_cmp++; if (r_done_cnt != 1) begin n_bad++; $display("FAIL rstmid.replay_done got %0d want 1", r_done_cnt); end
    n_cmp++; if (bus_q.size() != N_BUS) begin n_bad++; $display("FAIL rstmid.replay_bytes got %0d want %0d", bus_q.size(), N_BUS); end
    for (int i = 0; i < N_BUS && i < bus_q.size(); i++) begin
      n_cmp++;
      if (bus_q[i] !== exp_byte(i, 1'b0)) begin
        n_bad++; $display("FAIL rstmid.byte[%0d] got %h want %h", i, bus_q[i], exp_byte(i, 1'b0));
      end
    end
  endtask

`ifdef DBI_TE_SYNC_EN
  task automatic test_te();
    int slot_k, early_bad, dn;
    slot_k = 0; early_bad = 0; dn = 0;
    te_auto = 1'b0;
    te_man = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    frame_start = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      if (k == 10) te_man = 1'b1;
      if (slot_k == 0) begin
        if (wrx === 1'b0) begin
          slot_k = k;
          n_cmp++; if (d !== 8'h2A || dcx !== 1'b0 || csx !== 1'b0) begin n_bad++; $display("FAIL te.first_slot got d=%h dcx=%b csx=%b want 2A/0/0", d, dcx, csx); end
        end else if (csx !== 1'b1 || busy !== 1'b1) begin
          early_bad++;
        end
      end
      if (done === 1'b1) dn++;
      if (dn > 0) break;
    end
    n_cmp++; if (slot_k != 13) begin n_bad++; $display("FAIL te.slot_cycle got %0d want 13", slot_k); end
    n_cmp++; if (early_bad != 0) begin n_bad++; $display("FAIL te.wait_bus got %0d want 0", early_bad); end
    n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL te.done got %0d want 1", dn); end
    te_auto = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_a5_stream();
    test_stall();
    test_ignore_start();
    test_reset_mid_frame();
`ifdef DBI_TE_SYNC_EN
    test_te();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
